// File: rtl/mode4_pkg.sv
// Shared defaults, FSM state type and lane-sum width helper for the mode-4 row-sum datapath.
package mode4_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_BEATS  = 8;
    localparam int DEF_SUM_WIDTH  = 24;

    // Four unsigned lanes need two extra bits so the lane sum can never wrap.
    localparam int LANE_GROWTH    = 2;
    localparam int DEF_LANE_WIDTH = DEF_DATA_WIDTH + LANE_GROWTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } rowState_t;

    function automatic int laneWidth(input int dataWidth);
        return dataWidth + LANE_GROWTH;
    endfunction

endpackage

// File: rtl/mode4_rowsum_add4_tree.sv
// Combinational two-level adder tree summing the four exp-stage lanes of one beat.
module add4_tree
    import mode4_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]             i_a0,
    input  logic [DATA_WIDTH-1:0]             i_a1,
    input  logic [DATA_WIDTH-1:0]             i_a2,
    input  logic [DATA_WIDTH-1:0]             i_a3,
    output logic [DATA_WIDTH+LANE_GROWTH-1:0] o_sum
);

    logic [DATA_WIDTH:0] w_pairLo;
    logic [DATA_WIDTH:0] w_pairHi;

    assign w_pairLo = {1'b0, i_a0} + {1'b0, i_a1};
    assign w_pairHi = {1'b0, i_a2} + {1'b0, i_a3};
    assign o_sum    = {1'b0, w_pairLo} + {1'b0, w_pairHi};

endmodule

// File: rtl/mode4_rowsum.sv
// Row-sum stage: accumulates NUM_BEATS four-lane beats into a saturating sum and
// holds the result until the consumer takes it.
module mode4_rowsum
    import mode4_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_BEATS  = DEF_NUM_BEATS,
    parameter int SUM_WIDTH  = DEF_SUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] inp0,
    input  logic [DATA_WIDTH-1:0] inp1,
    input  logic [DATA_WIDTH-1:0] inp2,
    input  logic [DATA_WIDTH-1:0] inp3,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SUM_WIDTH-1:0]  sum_out,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic                  busy
);

    localparam int LANE_W = laneWidth(DATA_WIDTH);
    localparam int CNT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    rowState_t            r_state;
    logic [SUM_WIDTH-1:0] r_acc;
    logic [SUM_WIDTH-1:0] r_sumOut;
    logic [LANE_W-1:0]    r_laneSum;
    logic                 r_laneVld;
    logic [CNT_W-1:0]     r_beatCnt;
    logic                 r_inReady;
    logic                 r_sumValid;
    logic                 r_busy;

    logic [LANE_W-1:0]    w_laneSum;
    logic [SUM_WIDTH:0]   w_accSum;
    logic [SUM_WIDTH-1:0] w_accNext;
    logic                 w_accept;
    logic                 w_handshake;

    add4_tree #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_add4Tree (
        .i_a0  (inp0),
        .i_a1  (inp1),
        .i_a2  (inp2),
        .i_a3  (inp3),
        .o_sum (w_laneSum)
    );

    // r_inReady is only ever high in ACCUM, so it doubles as the state qualifier.
    assign w_accept    = r_inReady & in_valid;
    assign w_handshake = r_sumValid & sum_ready;

    // One extra carry bit detects overflow; an all-ones acc stays all-ones.
    assign w_accSum  = {1'b0, r_acc} + (SUM_WIDTH + 1)'(r_laneSum);
    assign w_accNext = w_accSum[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : w_accSum[SUM_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_sumOut   <= '0;
            r_laneSum  <= '0;
            r_laneVld  <= 1'b0;
            r_beatCnt  <= '0;
            r_inReady  <= 1'b0;
            r_sumValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_ACCUM;
                        r_acc     <= '0;
                        r_laneSum <= '0;
                        r_laneVld <= 1'b0;
                        r_beatCnt <= '0;
                        r_inReady <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                ST_ACCUM: begin
                    if (r_laneVld) begin
                        r_acc <= w_accNext;
                    end
                    r_laneVld <= w_accept;
                    if (w_accept) begin
                        r_laneSum <= w_laneSum;
                        if (r_beatCnt == LAST_BEAT) begin
                            r_state   <= ST_DRAIN;
                            r_inReady <= 1'b0;
                            r_beatCnt <= '0;
                        end else begin
                            r_beatCnt <= r_beatCnt + CNT_W'(1);
                        end
                    end
                end

                // The last accepted beat is still in the stage-1 register here.
                ST_DRAIN: begin
                    if (r_laneVld) begin
                        r_acc <= w_accNext;
                    end
                    r_laneVld <= 1'b0;
                    r_state   <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (w_handshake) begin
                        r_state    <= ST_IDLE;
                        r_sumValid <= 1'b0;
                        r_sumOut   <= '0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_sumValid <= 1'b1;
                        r_sumOut   <= r_acc;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_inReady  <= 1'b0;
                    r_sumValid <= 1'b0;
                    r_sumOut   <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign sum_out   = r_sumOut;
    assign sum_valid = r_sumValid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mode4_rowsum.sv
// Directed bench for mode4_rowsum: nominal row, bubbles with back-pressure, reset mid-row,
// ignored controls, and saturation on a 256-beat instance.
module tb_mode4_rowsum;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] inp0 = '0, inp1 = '0, inp2 = '0, inp3 = '0;
    logic        in_valid = 1'b0;
    logic        sum_ready = 1'b1;
    logic        in_ready, sum_valid, busy;
    logic [23:0] sum_out;

    logic        sStart = 1'b0;
    logic [15:0] sLane = '0;
    logic        sInValid = 1'b0;
    logic        sSumReady = 1'b1;
    logic        sInReady, sSumValid, sBusy;
    logic [23:0] sSumOut;

    int checks = 0;
    int failures = 0;
    bit feedSawValid;

    always #5 clk = ~clk;

    mode4_rowsum #(.DATA_WIDTH(16), .NUM_BEATS(8), .SUM_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .start(start),
        .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
    );

    mode4_rowsum #(.DATA_WIDTH(16), .NUM_BEATS(256), .SUM_WIDTH(24)) dutSat (
        .clk(clk), .reset(reset), .start(sStart),
        .inp0(sLane), .inp1(sLane), .inp2(sLane), .inp3(sLane),
        .in_valid(sInValid), .in_ready(sInReady),
        .sum_out(sSumOut), .sum_valid(sSumValid), .sum_ready(sSumReady), .busy(sBusy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds n accepted beats; gaps carry all-ones lanes so a wrongly consumed bubble shows up.
    task automatic feedBeats(input int n, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d, input bit bubbles);
        int  accepted = 0;
        int  cyc = 0;
        bit  phase = 1'b1;
        bit  take;
        feedSawValid = 1'b0;
        while (accepted < n && cyc < 4 * n + 20) begin
            in_valid = bubbles ? phase : 1'b1;
            if (in_valid) begin
                inp0 = a; inp1 = b; inp2 = c; inp3 = d;
            end else begin
                inp0 = 16'hFFFF; inp1 = 16'hFFFF; inp2 = 16'hFFFF; inp3 = 16'hFFFF;
            end
            take = in_ready && in_valid;
            if (sum_valid) feedSawValid = 1'b1;
            tick();
            if (take) accepted++;
            phase = ~phase;
            cyc++;
        end
        in_valid = 1'b0;
        if (accepted < n) begin
            checks++;
            failures++;
            $display("[TB] FAIL feed_timeout accepted=%0d required=%0d", accepted, n);
        end
    endtask

    task automatic waitValid(input int budget, input string name);
        int n = 0;
        while (!sum_valid && n < budget) begin
            tick();
            n++;
        end
        if (!sum_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_valid_timeout got=0 required=1 after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        sStart = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b required=0", in_ready); end
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_sum_valid got=%b required=0", sum_valid); end
        checks++; if (sum_out !== 24'h0) begin failures++; $display("[TB] FAIL reset_sum_out got=%h required=000000", sum_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_with_start got=%b required=0", busy); end
        checks++; if (sBusy !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat_busy got=%b required=0", sBusy); end
        start = 1'b0;
        sStart = 1'b0;
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle got=%b required=0", busy); end
    endtask

    task automatic test_nominal;
        sum_ready = 1'b1;
        pulseStart();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL nom_busy got=%b required=1", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL nom_in_ready got=%b required=1", in_ready); end
        feedBeats(8, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL nom_ready_drop got=%b required=0", in_ready); end
        checks++; if (sum_out !== 24'h0) begin failures++; $display("[TB] FAIL nom_drain_out got=%h required=000000", sum_out); end
        tick();
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL nom_early_valid got=%b required=0", sum_valid); end
        tick();
        checks++; if (sum_valid !== 1'b1) begin failures++; $display("[TB] FAIL nom_latency_valid got=%b required=1", sum_valid); end
        checks++; if (sum_out !== 24'h020000) begin failures++; $display("[TB] FAIL nom_sum got=%h required=020000", sum_out); end
        tick();
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL nom_valid_held got=%b required=0", sum_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL nom_idle got=%b required=0", busy); end
        checks++; if (sum_out !== 24'h0) begin failures++; $display("[TB] FAIL nom_idle_out got=%h required=000000", sum_out); end
    endtask

    task automatic test_backpressure;
        sum_ready = 1'b0;
        pulseStart();
        feedBeats(8, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        waitValid(6, "bp");
        for (int k = 0; k < 5; k++) begin
            checks++; if (sum_valid !== 1'b1 || sum_out !== 24'h000050) begin
                failures++;
                $display("[TB] FAIL bp_hold_%0d got valid=%b sum=%h required valid=1 sum=000050", k, sum_valid, sum_out);
            end
            tick();
        end
        sum_ready = 1'b1;
        tick();
        checks++; if (sum_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release got=%b required=0", sum_valid); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_idle got=%b required=0", busy); end
    endtask

    task automatic test_reset_midrow;
        bit sawValid = 1'b0;
        sum_ready = 1'b1;
        pulseStart();
        feedBeats(4, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrow_reset got busy=%b ready=%b required 0/0", busy, in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            if (sum_valid) sawValid = 1'b1;
            tick();
        end
        pulseStart();
        feedBeats(8, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);
        if (feedSawValid || sum_valid) sawValid = 1'b1;
        checks++; if (sawValid !== 1'b0) begin failures++; $display("[TB] FAIL midrow_stray_valid got=1 required=0"); end
        waitValid(5, "midrow");
        checks++; if (sum_out !== 24'h000020) begin failures++; $display("[TB] FAIL midrow_sum got=%h required=000020", sum_out); end
        tick();
    endtask

    task automatic test_ignored_controls;
        in_valid = 1'b1;
        inp0 = 16'h1000; inp1 = 16'h1000; inp2 = 16'h1000; inp3 = 16'h1000;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ign_idle got ready=%b busy=%b required 0/0", in_ready, busy);
        end
        pulseStart();
        feedBeats(3, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0);
        start = 1'b1;
        feedBeats(1, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0);
        start = 1'b0;
        feedBeats(4, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0);
        sum_ready = 1'b0;
        in_valid = 1'b1;
        inp0 = 16'h1000; inp1 = 16'h1000; inp2 = 16'h1000; inp3 = 16'h1000;
        waitValid(6, "ign");
        tick();
        checks++; if (sum_out !== 24'h000040) begin failures++; $display("[TB] FAIL ign_sum got=%h required=000040", sum_out); end
        sum_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ign_handshake_start got valid=%b busy=%b required 0/0", sum_valid, busy);
        end
        tick();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ign_stays_idle got busy=%b ready=%b required 0/0", busy, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation;
        int accepted = 0;
        int cyc = 0;
        int n = 0;
        bit take;
        sStart = 1'b1;
        tick();
        sStart = 1'b0;
        sLane = 16'hFFFF;
        while (accepted < 256 && cyc < 300) begin
            sInValid = 1'b1;
            take = sInReady;
            tick();
            if (take) accepted++;
            cyc++;
        end
        sInValid = 1'b0;
        checks++; if (accepted != 256) begin failures++; $display("[TB] FAIL sat_accept got=%0d required=256", accepted); end
        while (!sSumValid && n < 8) begin
            tick();
            n++;
        end
        checks++; if (sSumValid !== 1'b1) begin failures++; $display("[TB] FAIL sat_valid got=%b required=1", sSumValid); end
        checks++; if (sSumOut !== 24'hFFFFFF) begin failures++; $display("[TB] FAIL sat_sum got=%h required=ffffff", sSumOut); end
        tick();
        checks++; if (sSumValid !== 1'b0 || sBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_release got valid=%b busy=%b required 0/0", sSumValid, sBusy);
        end
    endtask

    initial begin
        $display("[TB] mode4_rowsum directed bench start");
        test_reset();
        test_nominal();
        test_backpressure();
        test_reset_midrow();
        test_ignored_controls();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mode4_rowsum.md
MODE4_ROWSUM -- requirements
Module: mode4_rowsum

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each exp-lane input, unsigned fixed point with 1.0 = 16'h1000.
REQ-002 Parameter NUM_BEATS, default 8: input beats per row (NUM_WORDS/4); legal range 1..256.
REQ-003 Parameter SUM_WIDTH, default 24: accumulator and result width.
REQ-004 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle pulse that opens a new row.
REQ-008 inp0..inp3  input  DATA_WIDTH each  exp-stage lane outputs for one beat.
REQ-009 in_valid  input  1  inp0..inp3 carry a valid beat.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 sum_out  output  SUM_WIDTH  completed row sum.
REQ-012 sum_valid  output  1  sum_out holds a completed row sum.
REQ-013 sum_ready  input  1  consumer accepts sum_out.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, DRAIN and HOLD.
REQ-016 IDLE: in_ready=0, sum_valid=0; start -> ACCUM, clearing the accumulator, the beat counter and the stage-1 register in the same edge.
REQ-017 ACCUM: in_ready=1; a beat is accepted when in_valid and in_ready are both high; gaps in in_valid SHALL stall without affecting state.
REQ-018 Stage 1: each accepted beat SHALL register lane_sum = inp0+inp1+inp2+inp3, zero-extended to DATA_WIDTH+2 bits with no truncation.
REQ-019 Stage 2: the cycle after a beat is accepted, acc SHALL become acc + lane_sum.
REQ-020 Saturation: if acc + lane_sum exceeds 2^SUM_WIDTH-1, acc SHALL become all-ones and remain all-ones for the rest of the row.
REQ-021 Beat counter SHALL count accepted beats 0..NUM_BEATS-1; acceptance at count NUM_BEATS-1 -> DRAIN, with in_ready low from the next cycle.
REQ-022 DRAIN SHALL last exactly one cycle, completing the final stage-2 add, then -> HOLD.
REQ-023 Latency: last beat accepted at edge t -> sum_valid high after edge t+2.
REQ-024 HOLD: sum_valid=1; sum_out SHALL be stable until sum_valid && sum_ready; on that handshake -> IDLE with sum_valid low the next cycle.
REQ-025 start SHALL be ignored in ACCUM, DRAIN and HOLD, including when it coincides with the HOLD handshake; a new row requires start in IDLE.
REQ-026 In_valid outside ACCUM SHALL be ignored; no beat is consumed.
REQ-027 sum_out SHALL read 0 in IDLE, ACCUM and DRAIN; it carries acc only in HOLD.

Reset
REQ-028 reset SHALL force IDLE, acc=0, lane_sum register=0 and beat counter=0, and drive in_ready=0, sum_valid=0, sum_out=0 and busy=0, taking priority over every other input in that cycle.
REQ-029 Reset mid-row (ACCUM, DRAIN or HOLD) SHALL discard the partial sum; no sum_valid pulse SHALL follow until a fresh start and a full row complete.

Structure
REQ-030 A shared package mode4_pkg SHALL hold DATA_WIDTH, SUM_WIDTH and NUM_BEATS defaults, the FSM state enum type and the lane-sum width constant (DATA_WIDTH+2).
REQ-031 One sub-module, add4_tree, SHALL implement the combinational 4-input lane adder; the FSM, counter, pipeline registers and saturating accumulator stay in mode4_rowsum.

Verification
REQ-032 Nominal: start, 8 beats with all lanes 16'h1000, sum_ready=1 -> sum_out=24'h020000, sum_valid exactly 2 cycles after the last accept, held 1 cycle.
REQ-033 Back-pressure with bubbles: in_valid toggled 1/0 across 8 beats of lanes {1,2,3,4}; sum_ready held low 5 cycles in HOLD -> sum_out=24'h000050, stable for all 5 cycles, IDLE after the handshake.
REQ-034 Saturation: NUM_BEATS=256, all lanes 16'hFFFF -> sum_out=24'hFFFFFF.
REQ-035 Reset mid-row: reset asserted after beat 4 of 8, then start and 8 beats of 16'h0001 -> sum_out=24'h000020, no earlier sum_valid.
REQ-036 Ignored controls: start pulsed in ACCUM and together with the HOLD handshake; in_valid=1 in IDLE with lanes 16'h1000 -> sum unchanged, block remains IDLE after the handshake, in_ready=0 in IDLE.
